dsi_unpacker: RTL and testbench

- Inverse of the DSI byte packer: accepts packed words of 1..g_input_bytes valid bytes and re-emits the byte stream as consumer-sized groups of 1..g_output_bytes bytes.
- Used on the host/readback side to split packed payload words into per-pixel or per-field byte groups before header, ECC or pixel decoders.
- Internal byte buffer with count tracking and request/valid handshakes on both sides.

---
 rtl/dsi_unpacker_if.sv | 39 +++
 rtl/dsi_unpacker.sv | 131 +++++++++++++
 tb/tb_dsi_unpacker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsi_unpacker_if.sv
// ---------------------------------------------------------------------------
// dsi_unpacker_if
//   Bundles the producer-side (packed word in) and consumer-side (byte group
//   out) signals of the DSI byte unpacker.
//
//   master : the environment. Drives the input words, the group requests
//            and flush, and observes the outputs.
//   slave  : the unpacker itself.
//
//   Producer side : d_i, d_size_i, d_valid_i  -> ; <- d_req_o
//   Consumer side : q_size_i, q_req_i, q_flush_i -> ; <- q_o, q_valid_o
//   Status        : <- d_empty_o, err_o
// ---------------------------------------------------------------------------
interface dsi_unpacker_if #(
    parameter int g_input_bytes  = 3,
    parameter int g_output_bytes = 3
);
    logic [8*g_input_bytes-1:0]  d_i;
    logic [3:0]                  d_size_i;
    logic                        d_valid_i;
    logic                        d_req_o;
    logic [2:0]                  q_size_i;
    logic                        q_req_i;
    logic [8*g_output_bytes-1:0] q_o;
    logic [g_output_bytes-1:0]   q_valid_o;
    logic                        q_flush_i;
    logic                        d_empty_o;
    logic                        err_o;

    modport master (
        output d_i, d_size_i, d_valid_i, q_size_i, q_req_i, q_flush_i,
        input  d_req_o, q_o, q_valid_o, d_empty_o, err_o
    );

    modport slave (
        input  d_i, d_size_i, d_valid_i, q_size_i, q_req_i, q_flush_i,
        output d_req_o, q_o, q_valid_o, d_empty_o, err_o
    );
endinterface

// File: rtl/dsi_unpacker.sv
// ---------------------------------------------------------------------------
// dsi_unpacker
//   Splits packed words of 1..g_input_bytes bytes back into a byte stream and
//   hands it out as groups of 1..g_output_bytes bytes on request.
//
//   Ports:
//     clk_i  : clock
//     rst_i  : asynchronous reset, active high
//     bus    : dsi_unpacker_if.slave
//              d_i/d_size_i/d_valid_i/d_req_o  packed input words
//              q_size_i/q_req_i/q_o/q_valid_o  requested output groups
//              q_flush_i                       drop everything buffered
//              d_empty_o                       buffer holds no bytes
//              err_o                           one-cycle protocol error pulse
//
//   The buffer is a packed vector with byte 0 (bits [7:0]) the oldest byte.
//   Bytes at or above the fill count are always zero, so a read is a plain
//   right shift and an append is an OR of the new bytes shifted to the fill
//   position. c_buf_bytes must not exceed 31 so the count fits in 5 bits.
// ---------------------------------------------------------------------------
module dsi_unpacker #(
    parameter int g_input_bytes  = 3,
    parameter int g_output_bytes = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dsi_unpacker_if.slave  bus
);
    localparam int c_max_bytes = (g_input_bytes > g_output_bytes) ? g_input_bytes : g_output_bytes;
    localparam int c_buf_bytes = 2 * c_max_bytes + 2;
    localparam int c_buf_w     = 8 * c_buf_bytes;
    localparam int c_in_w      = 8 * g_input_bytes;
    localparam int c_out_w     = 8 * g_output_bytes;

    // state
    logic [4:0]                count_q,   count_d;
    logic [c_buf_w-1:0]        buf_q,     buf_d;
    logic [c_out_w-1:0]        q_q,       q_d;
    logic [g_output_bytes-1:0] q_valid_q, q_valid_d;
    logic                      err_q,     err_d;

    // decode
    logic                      d_req;
    logic                      wr_size_ok;
    logic                      rd_size_ok;
    logic                      wr_ok;
    logic                      rd_ok;
    logic [2:0]                rd_n;
    logic [2:0]                rd_pad;
    logic [4:0]                wr_base;
    logic [c_in_w-1:0]         wr_keep;
    logic [c_buf_w-1:0]        wr_ext;
    logic [c_out_w-1:0]        rd_rev;
    logic [g_output_bytes-1:0] rd_mask;

    assign d_req      = (5'(c_buf_bytes) - count_q) >= 5'(g_input_bytes);
    assign wr_size_ok = (bus.d_size_i != 4'd0) && (bus.d_size_i <= 4'(g_input_bytes));
    assign rd_size_ok = (bus.q_size_i != 3'd0) && (bus.q_size_i <= 3'(g_output_bytes));
    assign wr_ok      = bus.d_valid_i && d_req && wr_size_ok;
    // Reads only look at the count at cycle start; bytes written this
    // cycle are never visible to a read in the same cycle.
    assign rd_ok      = bus.q_req_i && rd_size_ok && (count_q >= {2'b00, bus.q_size_i});
    assign rd_n       = rd_ok ? bus.q_size_i : 3'd0;
    assign rd_pad     = 3'(g_output_bytes) - rd_n;
    assign wr_base    = count_q - {2'b00, rd_n};

    // Keep only the valid lanes of the input word so stale upper lanes never
    // pollute the zero region of the buffer.
    for (genvar gi = 0; gi < g_input_bytes; gi++) begin : g_wr_keep
        assign wr_keep[8*gi +: 8] = (bus.d_size_i > 4'(gi)) ? 8'hFF : 8'h00;
    end
    assign wr_ext = c_buf_w'(bus.d_i & wr_keep);

    // Reverse the oldest g_output_bytes bytes so the oldest lands in the top
    // lane; shifting right by the unused lane count then right-justifies an
    // n-byte group with its first byte most significant and zero upper lanes.
    for (genvar gi = 0; gi < g_output_bytes; gi++) begin : g_rd_lane
        assign rd_rev[8*gi +: 8] = buf_q[8*(g_output_bytes-1-gi) +: 8];
        assign rd_mask[gi]       = (rd_n > 3'(gi));
    end

    always_comb begin
        count_d   = count_q;
        buf_d     = buf_q;
        q_d       = q_q;
        q_valid_d = '0;
        err_d     = (bus.d_valid_i && !(d_req && wr_size_ok)) ||
                    (bus.q_req_i && !rd_size_ok);

        if (bus.q_flush_i) begin
            // Flush wins over everything, including error reporting.
            count_d = 5'd0;
            buf_d   = '0;
            err_d   = 1'b0;
        end else begin
            buf_d   = (buf_q >> {rd_n, 3'b000}) |
                      (wr_ok ? (wr_ext << {wr_base, 3'b000}) : '0);
            count_d = wr_base + (wr_ok ? {1'b0, bus.d_size_i} : 5'd0);
            if (rd_ok) begin
                q_d       = rd_rev >> {rd_pad, 3'b000};
                q_valid_d = rd_mask;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= 5'd0;
            buf_q     <= '0;
            q_q       <= '0;
            q_valid_q <= '0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            buf_q     <= buf_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.d_req_o   = d_req;
    assign bus.d_empty_o = (count_q == 5'd0);
    assign bus.q_o       = q_q;
    assign bus.q_valid_o = q_valid_q;
    assign bus.err_o     = err_q;

    // Writes are gated by d_req, so the count can never pass the depth.
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= 5'(c_buf_bytes));
endmodule

// File: tb/tb_dsi_unpacker.sv
// ---------------------------------------------------------------------------
// tb_dsi_unpacker
//   Drives dsi_unpacker (4-byte input words, 3-byte output groups, 10-byte
//   buffer) with directed and random traffic. A byte-queue model predicts
//   each cycle's outcome; a separate monitor compares the DUT outputs.
// ---------------------------------------------------------------------------
module tb_dsi_unpacker;
    localparam int GI = 4;
    localparam int GO = 3;
    localparam int CB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsi_unpacker_if #(.g_input_bytes(GI), .g_output_bytes(GO)) bus ();

    dsi_unpacker #(.g_input_bytes(GI), .g_output_bytes(GO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int due;
        bit err;
        int n;
    } status_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    bit            mon_en   = 1'b0;
    status_t       st_q[$];
    logic [23:0]   grp_q[$];
    byte unsigned  model[$];
    logic [23:0]   last_q   = '0;
    status_t       mon_s;
    logic [2:0]    mon_mask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one status entry per cycle, one group entry per delivered group.
    always @(negedge clk) begin
        if (mon_en && !rst && st_q.size() > 0 && st_q[0].due <= cyc) begin
            mon_s    = st_q.pop_front();
            mon_mask = 3'((1 << mon_s.n) - 1);
            chk("err_o", 32'(bus.err_o), 32'(mon_s.err));
            chk("q_valid_o", 32'(bus.q_valid_o), 32'(mon_mask));
            if (mon_s.n > 0) begin
                if (grp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grp_queue: got empty expected entry (cycle %0d)", cyc);
                end else begin
                    last_q = grp_q.pop_front();
                    chk("q_o", 32'(bus.q_o), 32'(last_q));
                    $display("group n=%0d q_o=%06h expected=%06h", mon_s.n, bus.q_o, last_q);
                end
            end else begin
                chk("q_o_hold", 32'(bus.q_o), 32'(last_q));
            end
        end
    end

    // One cycle of stimulus: check level outputs, drive, predict, advance.
    task automatic step(bit dv, int dsz, logic [31:0] d, bit qr, int qsz, bit fl);
        status_t     s;
        logic [23:0] g;
        bit          dreq;
        bit          wr_legal;
        bit          rd_legal;
        dreq = (CB - model.size()) >= GI;
        chk("d_req_o", 32'(bus.d_req_o), 32'(dreq));
        chk("d_empty_o", 32'(bus.d_empty_o), 32'(model.size() == 0));
        bus.d_valid_i = dv;
        bus.d_size_i  = 4'(dsz);
        bus.d_i       = d;
        bus.q_req_i   = qr;
        bus.q_size_i  = 3'(qsz);
        bus.q_flush_i = fl;
        s.due = cyc + 1;
        s.err = 1'b0;
        s.n   = 0;
        if (fl) begin
            model.delete();
        end else begin
            wr_legal = (dsz >= 1) && (dsz <= GI);
            rd_legal = (qsz >= 1) && (qsz <= GO);
            if (qr && !rd_legal) s.err = 1'b1;
            if (dv && !(dreq && wr_legal)) s.err = 1'b1;
            if (qr && rd_legal && model.size() >= qsz) begin
                g = '0;
                for (int k = 0; k < qsz; k++) g = (g << 8) | 24'(model.pop_front());
                grp_q.push_back(g);
                s.n = qsz;
            end
            if (dv && dreq && wr_legal)
                for (int k = 0; k < dsz; k++) model.push_back(d[8*k +: 8]);
        end
        st_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic reset_midcycle();
        bus.d_valid_i = 1'b0;
        bus.q_req_i   = 1'b0;
        bus.q_flush_i = 1'b0;
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_q_valid_o", 32'(bus.q_valid_o), 32'h0);
        chk("rst_q_o", 32'(bus.q_o), 32'h0);
        chk("rst_err_o", 32'(bus.err_o), 32'h0);
        chk("rst_d_req_o", 32'(bus.d_req_o), 32'h1);
        chk("rst_d_empty_o", 32'(bus.d_empty_o), 32'h1);
        model.delete();
        st_q.delete();
        grp_q.delete();
        last_q = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit dv, qr, fl;
        int dsz, qsz;
        bus.d_i       = '0;
        bus.d_size_i  = '0;
        bus.d_valid_i = 1'b0;
        bus.q_size_i  = '0;
        bus.q_req_i   = 1'b0;
        bus.q_flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_q_valid_o", 32'(bus.q_valid_o), 32'h0);
        chk("init_d_empty_o", 32'(bus.d_empty_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // basic split, stall, refill
        step(1'b1, 4, 32'h44332211, 1'b0, 0, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 3, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 3, 1'b0);
        step(1'b1, 2, 32'h00006655, 1'b1, 3, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 3, 1'b0);
        idle();

        // write and read in the same cycle from empty
        step(1'b1, 3, 32'h00CCBBAA, 1'b1, 2, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 2, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 1, 1'b0);
        idle();

        // backpressure
        step(1'b1, 4, 32'h04030201, 1'b0, 0, 1'b0);
        step(1'b1, 4, 32'h08070605, 1'b0, 0, 1'b0);
        step(1'b1, 4, 32'h0C0B0A09, 1'b0, 0, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 3, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 3, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 2, 1'b0);
        idle();

        // flush with simultaneous write and read
        step(1'b1, 3, 32'h00333231, 1'b0, 0, 1'b0);
        step(1'b1, 3, 32'h00363534, 1'b0, 0, 1'b0);
        step(1'b1, 4, 32'h3A393837, 1'b1, 3, 1'b1);
        idle();

        // illegal sizes
        step(1'b1, 1, 32'h000000E1, 1'b0, 0, 1'b0);
        step(1'b1, 0, 32'h000000E2, 1'b0, 0, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 4, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 1, 1'b0);
        idle();

        // asynchronous reset in the middle of traffic
        step(1'b1, 4, 32'h77665544, 1'b0, 0, 1'b0);
        step(1'b0, 0, 32'h0,        1'b1, 3, 1'b0);
        reset_midcycle();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            dv  = $urandom_range(0, 99) < 55;
            dsz = ($urandom_range(0, 99) < 3) ?
                  (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 15))) :
                  int'($urandom_range(1, GI));
            qr  = $urandom_range(0, 99) < 60;
            qsz = ($urandom_range(0, 99) < 3) ?
                  (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(4, 7))) :
                  int'($urandom_range(1, GO));
            fl  = $urandom_range(0, 99) < 2;
            step(dv, dsz, $urandom, qr, qsz, fl);
        end

        repeat (3) idle();
        @(negedge clk);
        #1;
        chk("status_queue_drained", 32'(st_q.size()), 32'h0);
        chk("group_queue_drained", 32'(grp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
